// File: rtl/pipelined_add_sub.sv
// Pipelined two's-complement adder/subtractor: one SEG-bit slice per stage, carry registered
// between stages, valid/ready handshake with a single global advance for clean back-pressure.
module pipelined_add_sub #(
    parameter int WIDTH = 16,
    parameter int SEG   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);
    localparam int STAGES = WIDTH / SEG;

    logic adv_s;

    generate
        for (genvar k = 0; k < STAGES; k++) begin : g_stage
            // Operand bits not yet consumed; the low SEG bits are this stage's slice.
            localparam int HI = WIDTH - k * SEG;

            logic [HI-1:0]          a_hi_s;
            logic [HI-1:0]          b_hi_s;
            logic                   c_s;
            logic                   v_s;
            logic [SEG:0]           add_s;
            logic [(k+1)*SEG-1:0]   res_next_s;
            logic [(k+1)*SEG-1:0]   res_r;
            logic                   carry_r;
            logic                   valid_r;

            assign add_s = {1'b0, a_hi_s[SEG-1:0]} + {1'b0, b_hi_s[SEG-1:0]} + {{SEG{1'b0}}, c_s};

            if (k == 0) begin : g_head
                assign a_hi_s     = a;
                assign b_hi_s     = sub ? ~b : b;
                assign c_s        = sub ? 1'b1 : cin;
                assign v_s        = in_valid;
                assign res_next_s = add_s[SEG-1:0];
            end else begin : g_body
                assign a_hi_s     = g_stage[k-1].g_fwd.a_r;
                assign b_hi_s     = g_stage[k-1].g_fwd.b_r;
                assign c_s        = g_stage[k-1].carry_r;
                assign v_s        = g_stage[k-1].valid_r;
                assign res_next_s = {add_s[SEG-1:0], g_stage[k-1].res_r};
            end

            // Stage valid, carry and result skew register; data only moves with a valid beat.
            always_ff @(posedge clk) begin
                if (rst) begin
                    valid_r <= 1'b0;
                    carry_r <= 1'b0;
                    res_r   <= {((k+1)*SEG){1'b0}};
                end else if (adv_s) begin
                    valid_r <= v_s;
                    if (v_s) begin
                        carry_r <= add_s[SEG];
                        res_r   <= res_next_s;
                    end
                end
            end

            if (k < STAGES - 1) begin : g_fwd
                logic [HI-SEG-1:0] a_r;
                logic [HI-SEG-1:0] b_r;

                // Unskew chain: upper operand slices wait for their stage.
                always_ff @(posedge clk) begin
                    if (rst) begin
                        a_r <= {(HI-SEG){1'b0}};
                        b_r <= {(HI-SEG){1'b0}};
                    end else if (adv_s && v_s) begin
                        a_r <= a_hi_s[HI-1:SEG];
                        b_r <= b_hi_s[HI-1:SEG];
                    end
                end
            end else begin : g_tail
                logic ovf_r;

                // Signed overflow: operands agree in sign but the result sign differs.
                always_ff @(posedge clk) begin
                    if (rst) begin
                        ovf_r <= 1'b0;
                    end else if (adv_s && v_s) begin
                        ovf_r <= (a_hi_s[SEG-1] == b_hi_s[SEG-1]) && (add_s[SEG-1] != a_hi_s[SEG-1]);
                    end
                end
            end
        end
    endgenerate

    assign out_valid = g_stage[STAGES-1].valid_r;
    assign adv_s     = !out_valid || out_ready;
    assign in_ready  = adv_s;
    assign sum       = g_stage[STAGES-1].res_r;
    assign cout      = g_stage[STAGES-1].carry_r;
    assign ovf       = g_stage[STAGES-1].g_tail.ovf_r;
    assign zero      = (sum == {WIDTH{1'b0}});

endmodule
